cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_pkg.sv | 36 +++
 rtl/cond_logic_if.sv | 35 +++
 rtl/cond_check.sv | 39 +++
 rtl/cond_logic.sv | 74 +++++++
 tb/tb_cond_logic.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared condition-code constants, flag bit positions and the pipelined control bundle
// used by the conditional-execution logic.
package cond_pkg;

    localparam logic [3:0] EQ = 4'b0000;
    localparam logic [3:0] NE = 4'b0001;
    localparam logic [3:0] CS = 4'b0010;
    localparam logic [3:0] CC = 4'b0011;
    localparam logic [3:0] MI = 4'b0100;
    localparam logic [3:0] PL = 4'b0101;
    localparam logic [3:0] VS = 4'b0110;
    localparam logic [3:0] VC = 4'b0111;
    localparam logic [3:0] HI = 4'b1000;
    localparam logic [3:0] LS = 4'b1001;
    localparam logic [3:0] GE = 4'b1010;
    localparam logic [3:0] LT = 4'b1011;
    localparam logic [3:0] GT = 4'b1100;
    localparam logic [3:0] LE = 4'b1101;
    localparam logic [3:0] AL = 4'b1110;
    localparam logic [3:0] NV = 4'b1111;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    localparam int unsigned FailCountWidth = 16;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memwrite;
        logic valid;
    } m_ctrl_t;

endpackage

// File: rtl/cond_logic_if.sv
// Execute-stage control bundle between the decoder/ALU side and the conditional logic.
interface cond_logic_if;
    logic        Valid;
    logic        Stall;
    logic        Flush;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  Flagw;
    logic        PCS;
    logic        RegWR;
    logic        MemWR;
    logic        NoWrite;
    logic        PCSrc;
    logic        RegWrite;
    logic        MemWrite;
    logic        CondEx;
    logic [3:0]  Flags;
    logic        PCSrcM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ValidM;
    logic [15:0] FailCount;

    modport master (
        output Valid, Stall, Flush, Cond, ALUFlags, Flagw, PCS, RegWR, MemWR, NoWrite,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, PCSrcM, RegWriteM, MemWriteM,
               ValidM, FailCount
    );

    modport slave (
        input  Valid, Stall, Flush, Cond, ALUFlags, Flagw, PCS, RegWR, MemWR, NoWrite,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, PCSrcM, RegWriteM, MemWriteM,
               ValidM, FailCount
    );
endinterface

// File: rtl/cond_check.sv
// Purely combinational evaluation of an instruction condition field against the
// architectural {N,Z,C,V} flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);
    logic n, z, c, v;

    assign n = Flags[FlagN];
    assign z = Flags[FlagZ];
    assign c = Flags[FlagC];
    assign v = Flags[FlagV];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            EQ: CondEx = z;
            NE: CondEx = ~z;
            CS: CondEx = c;
            CC: CondEx = ~c;
            MI: CondEx = n;
            PL: CondEx = ~n;
            VS: CondEx = v;
            VC: CondEx = ~v;
            HI: CondEx = c & ~z;
            LS: CondEx = ~c | z;
            GE: CondEx = (n == v);
            LT: CondEx = (n != v);
            GT: CondEx = ~z & (n == v);
            LE: CondEx = z | (n != v);
            AL: CondEx = 1'b1;
            NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: gates decoder write/branch controls by the condition field,
// owns the flag register, the M-stage control copy and the annulled-instruction counter.
module cond_logic
    import cond_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    cond_logic_if.slave bus
);
    logic [3:0]                flags_q;
    m_ctrl_t                   m_d, m_q;
    logic [FailCountWidth-1:0] fail_count_q;
    logic                      cond_ex;
    logic                      commit;
    logic                      fire;

    cond_check u_cond_check (
        .Cond   (bus.Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    // Flush outranks Stall, which outranks Valid.
    assign commit = bus.Valid & ~bus.Stall & ~bus.Flush;
    assign fire   = commit & cond_ex;

    always_comb begin
        m_d          = '0;
        m_d.pcsrc    = fire & bus.PCS;
        m_d.regwrite = fire & bus.RegWR & ~bus.NoWrite;
        m_d.memwrite = fire & bus.MemWR;
        m_d.valid    = fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            if (fire && bus.Flagw[1]) begin
                flags_q[FlagN:FlagZ] <= bus.ALUFlags[FlagN:FlagZ];
            end
            if (fire && bus.Flagw[0]) begin
                flags_q[FlagC:FlagV] <= bus.ALUFlags[FlagC:FlagV];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
        end else begin
            m_q <= m_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_count_q <= '0;
        end else if (commit && !cond_ex && (fail_count_q != '1)) begin
            fail_count_q <= fail_count_q + 1'b1;
        end
    end

    assign bus.PCSrc     = m_d.pcsrc;
    assign bus.RegWrite  = m_d.regwrite;
    assign bus.MemWrite  = m_d.memwrite;
    assign bus.CondEx    = cond_ex;
    assign bus.Flags     = flags_q;
    assign bus.PCSrcM    = m_q.pcsrc;
    assign bus.RegWriteM = m_q.regwrite;
    assign bus.MemWriteM = m_q.memwrite;
    assign bus.ValidM    = m_q.valid;
    assign bus.FailCount = fail_count_q;
endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: a reference model predicts M-stage controls into a
// scoreboard queue, popped and compared after each clock edge.
module tb_cond_logic;
    logic clk;
    logic rst_n;
    int   total_cnt;
    int   pass_cnt;

    logic [3:0]  model_flags;
    logic [15:0] model_fail;
    logic [3:0]  sb_q[$];

    cond_logic_if bus ();

    cond_logic u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard consumer: M-stage outputs settle just after the edge.
    always begin
        logic [3:0] exp_m;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            exp_m = sb_q.pop_front();
            total_cnt++;
            if ({bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.ValidM} !== exp_m)
                $display("FAIL m_stage: got %b expected %b at %0t",
                         {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.ValidM}, exp_m, $time);
            else
                pass_cnt++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, time %0t expected < 5ms", $time);
        $fatal(1);
    end

    task automatic drive(input logic v, input logic s, input logic f, input logic [3:0] cond,
                         input logic [3:0] alu, input logic [1:0] fw, input logic pcs,
                         input logic regwr, input logic memwr, input logic nowr);
        bus.Valid = v;   bus.Stall = s;    bus.Flush = f;    bus.Cond = cond;
        bus.ALUFlags = alu; bus.Flagw = fw; bus.PCS = pcs;   bus.RegWR = regwr;
        bus.MemWR = memwr;  bus.NoWrite = nowr;
        #1;
    endtask

    // Predict the M-stage result of the currently driven inputs, then clock once.
    task automatic tick();
        logic commit, ce, fire;
        commit = bus.Valid && !bus.Stall && !bus.Flush;
        ce     = cond_ref(bus.Cond, model_flags);
        fire   = commit && ce;
        sb_q.push_back({fire && bus.PCS, fire && bus.RegWR && !bus.NoWrite,
                        fire && bus.MemWR, fire});
        @(posedge clk);
        if (fire && bus.Flagw[1]) model_flags[3:2] = bus.ALUFlags[3:2];
        if (fire && bus.Flagw[0]) model_flags[1:0] = bus.ALUFlags[1:0];
        if (commit && !ce && model_fail != 16'hFFFF) model_fail = model_fail + 16'd1;
        #2;
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(1, 0, 0, 4'b1110, f, 2'b11, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
        #3;
        total_cnt++;
        if ({bus.Flags, bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.ValidM, bus.FailCount}
            !== 24'h0) $display("FAIL reset_init: got flags=%b m=%b fc=%h expected all zero",
            bus.Flags, {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.ValidM}, bus.FailCount);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        model_flags = 4'b0000;
        model_fail  = 16'd0;
        set_flags(4'b1111);
        drive(1, 0, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
        tick();
        total_cnt++;
        if (bus.Flags !== 4'b1111 || bus.FailCount !== 16'd1)
            $display("FAIL pre_reset_state: got flags=%b fc=%0d expected 1111 1",
                     bus.Flags, bus.FailCount);
        else pass_cnt++;
        // Asynchronous assertion between edges; NE must now see Z=0.
        drive(1, 0, 0, 4'b0001, 4'b1111, 2'b11, 1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.Flags, bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.ValidM, bus.FailCount}
            !== 24'h0) $display("FAIL async_reset: got flags=%b m=%b fc=%h expected all zero",
            bus.Flags, {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.ValidM}, bus.FailCount);
        else pass_cnt++;
        total_cnt++;
        if (bus.PCSrc !== 1'b1 || bus.CondEx !== 1'b1)
            $display("FAIL reset_comb: got pcsrc=%b condex=%b expected 1 1",
                     bus.PCSrc, bus.CondEx);
        else pass_cnt++;
        drive(1, 0, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        total_cnt++;
        if (bus.Flags !== 4'b0000 || bus.ValidM !== 1'b0)
            $display("FAIL reset_hold: got flags=%b validm=%b expected 0000 0",
                     bus.Flags, bus.ValidM);
        else pass_cnt++;
        rst_n = 1'b1;
        model_flags = 4'b0000;
        model_fail  = 16'd0;
        tick();
        total_cnt++;
        if (bus.Flags !== 4'b1111)
            $display("FAIL reset_release: got flags=%b expected 1111", bus.Flags);
        else pass_cnt++;
    endtask

    task automatic test_cmp_beq();
        set_flags(4'b0000);
        drive(1, 0, 0, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1);
        total_cnt++;
        if (bus.RegWrite !== 1'b0 || bus.CondEx !== 1'b1)
            $display("FAIL cmp_regwrite: got regwrite=%b condex=%b expected 0 1",
                     bus.RegWrite, bus.CondEx);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.Flags !== 4'b0100)
            $display("FAIL cmp_flags: got %b expected 0100", bus.Flags);
        else pass_cnt++;
        drive(1, 0, 0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
        total_cnt++;
        if (bus.PCSrc !== 1'b1)
            $display("FAIL beq_pcsrc: got %b expected 1", bus.PCSrc);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.PCSrcM !== 1'b1)
            $display("FAIL beq_pcsrcm: got %b expected 1", bus.PCSrcM);
        else pass_cnt++;
    endtask

    task automatic test_cond_fail();
        logic [15:0] fc0;
        set_flags(4'b0000);
        fc0 = bus.FailCount;
        drive(1, 0, 0, 4'b0000, 4'b1111, 2'b11, 0, 0, 1, 0);
        total_cnt++;
        if (bus.MemWrite !== 1'b0)
            $display("FAIL fail_memwrite: got %b expected 0", bus.MemWrite);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.Flags !== 4'b0000 || bus.FailCount !== fc0 + 16'd1)
            $display("FAIL fail_state: got flags=%b fc=%0d expected 0000 %0d",
                     bus.Flags, bus.FailCount, fc0 + 16'd1);
        else pass_cnt++;
    endtask

    task automatic test_partial_write();
        set_flags(4'b0000);
        drive(1, 0, 0, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0);
        tick();
        total_cnt++;
        if (bus.Flags !== 4'b1100)
            $display("FAIL partial_nz: got %b expected 1100", bus.Flags);
        else pass_cnt++;
        drive(1, 0, 0, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0);
        tick();
        total_cnt++;
        if (bus.Flags !== 4'b1100)
            $display("FAIL partial_cv: got %b expected 1100", bus.Flags);
        else pass_cnt++;
    endtask

    task automatic test_signed_compare();
        logic [3:0] pats[4];
        logic [3:0] exp_ce;
        set_flags(4'b1000);
        exp_ce = 4'b0100;  // LT, GT, GE expectations packed
        for (int i = 0; i < 3; i++) begin
            logic [3:0] cond;
            cond = (i == 0) ? 4'b1011 : (i == 1) ? 4'b1100 : 4'b1010;
            drive(0, 0, 0, cond, 4'b0000, 2'b00, 0, 0, 0, 0);
            total_cnt++;
            if (bus.CondEx !== exp_ce[2 - i])
                $display("FAIL signed_cond%b: got %b expected %b", cond, bus.CondEx,
                         exp_ce[2 - i]);
            else pass_cnt++;
        end
        pats[0] = 4'b0110; pats[1] = 4'b1011; pats[2] = 4'b0001; pats[3] = 4'b1110;
        for (int p = 0; p < 4; p++) begin
            set_flags(pats[p]);
            for (int c = 0; c < 16; c++) begin
                drive(1, 0, 0, c[3:0], 4'b0000, 2'b00, 1, 1, 1, 0);
                total_cnt++;
                if (bus.CondEx !== cond_ref(c[3:0], pats[p]))
                    $display("FAIL cond_table flags=%b cond=%0d: got %b expected %b",
                             pats[p], c, bus.CondEx, cond_ref(c[3:0], pats[p]));
                else pass_cnt++;
                tick();
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [15:0] fc0;
        logic [3:0]  f0;
        set_flags(4'b0101);
        f0  = bus.Flags;
        fc0 = bus.FailCount;
        drive(1, 1, 0, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, 0);
        total_cnt++;
        if ({bus.PCSrc, bus.RegWrite, bus.MemWrite} !== 3'b000)
            $display("FAIL stall_outputs: got %b expected 000",
                     {bus.PCSrc, bus.RegWrite, bus.MemWrite});
        else pass_cnt++;
        tick();
        drive(1, 1, 0, 4'b1111, 4'b1010, 2'b11, 0, 1, 0, 0);
        tick();
        total_cnt++;
        if (bus.Flags !== f0 || bus.FailCount !== fc0)
            $display("FAIL stall_hold: got flags=%b fc=%0d expected %b %0d",
                     bus.Flags, bus.FailCount, f0, fc0);
        else pass_cnt++;
        drive(1, 1, 1, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, 0);
        total_cnt++;
        if ({bus.PCSrc, bus.RegWrite, bus.MemWrite} !== 3'b000)
            $display("FAIL flush_outputs: got %b expected 000",
                     {bus.PCSrc, bus.RegWrite, bus.MemWrite});
        else pass_cnt++;
        tick();
        drive(1, 0, 1, 4'b1111, 4'b1010, 2'b11, 0, 0, 0, 0);
        tick();
        total_cnt++;
        if (bus.Flags !== f0 || bus.FailCount !== fc0)
            $display("FAIL flush_hold: got flags=%b fc=%0d expected %b %0d",
                     bus.Flags, bus.FailCount, f0, fc0);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
        while (model_fail != 16'hFFFF) tick();
        total_cnt++;
        if (bus.FailCount !== 16'hFFFF)
            $display("FAIL sat_reach: got %h expected ffff", bus.FailCount);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (bus.FailCount !== 16'hFFFF)
            $display("FAIL sat_hold: got %h expected ffff", bus.FailCount);
        else pass_cnt++;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        model_flags = 4'b0000;
        model_fail  = 16'd0;
        test_reset();
        test_cmp_beq();
        test_cond_fail();
        test_partial_write();
        test_signed_compare();
        test_stall_flush();
        test_saturation();
        @(posedge clk);
        #3;
        total_cnt++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
